// File: rtl/mul_pkg.sv
// Shared opcodes, state encoding and default width for the iterative multiplier.
package mul_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_UMULL = 3'b101;
    localparam logic [2:0] OP_SMULL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational conditional two's-complement negate (abs when neg_i is the sign bit).
module mul_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/UMULL/SMULL with N/Z flags.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flags_nz
);

    localparam int PW = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               bad_q, bad_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [1:0]         nz_q, nz_d;

    logic               legal, is_smull, last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [PW-1:0]      acc_sum, acc_fix;

    assign legal    = (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
    assign is_smull = (op == OP_SMULL);
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MUL_EARLY_TERM_EN
    assign last = (cnt_q == CNT_W'(WIDTH-1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last = (cnt_q == CNT_W'(WIDTH-1));
`endif

    mul_sign_fix #(.W(WIDTH)) u_abs_a (.val_i(a), .neg_i(is_smull & a[WIDTH-1]), .res_o(abs_a));
    mul_sign_fix #(.W(WIDTH)) u_abs_b (.val_i(b), .neg_i(is_smull & b[WIDTH-1]), .res_o(abs_b));
    mul_sign_fix #(.W(PW))    u_res   (.val_i(acc_sum), .neg_i(neg_q), .res_o(acc_fix));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        bad_d    = bad_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        lo_d     = lo_q;
        hi_d     = hi_q;
        nz_d     = nz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    acc_d = '0;
                    cnt_d = '0;
                    if (legal) begin
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
                        neg_d    = is_smull & (a[WIDTH-1] ^ b[WIDTH-1]);
                        bad_d    = 1'b0;
                        state_d  = RUN;
                    end else begin
                        neg_d   = 1'b0;
                        bad_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    acc_d   = acc_fix;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Results are published together with the done pulse and then held.
                done_d  = 1'b1;
                err_d   = bad_q;
                lo_d    = acc_q[WIDTH-1:0];
                if (bad_q) begin
                    hi_d = '0;
                    nz_d = 2'b00;
                end else if (op_q == OP_MUL) begin
                    hi_d = '0;
                    nz_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:0] == '0};
                end else begin
                    hi_d = acc_q[PW-1:WIDTH];
                    nz_d = {acc_q[PW-1], acc_q == '0};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            bad_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            nz_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            bad_q    <= bad_d;
            done_q   <= done_d;
            err_q    <= err_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            nz_q     <= nz_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign err       = err_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign flags_nz  = nz_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, err;
    logic [31:0] result_lo, result_hi;
    logic [1:0]  flags_nz;

    int nchk = 0;
    int nerr = 0;

    mul_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .err(err),
        .result_lo(result_lo), .result_hi(result_hi), .flags_nz(flags_nz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xs, ys, p;
        case (o)
            3'b100: begin p = {32'd0, x} * {32'd0, y}; ref_prod = {32'd0, p[31:0]}; end
            3'b101: ref_prod = {32'd0, x} * {32'd0, y};
            3'b110: begin
                xs = {{32{x[31]}}, x};
                ys = {{32{y[31]}}, y};
                ref_prod = xs * ys;
            end
            default: ref_prod = 64'd0;
        endcase
    endfunction

    function automatic logic [1:0] ref_nz(input logic [2:0] o, input logic [63:0] p);
        if (o == 3'b100)      ref_nz = {p[31], p[31:0] == 32'd0};
        else if (o == 3'b101 || o == 3'b110) ref_nz = {p[63], p == 64'd0};
        else                  ref_nz = 2'b00;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] y);
        logic [31:0] m;
        int hb;
        if (!(o == 3'b100 || o == 3'b101 || o == 3'b110)) return 1;
`ifdef MUL_EARLY_TERM_EN
        m  = (o == 3'b110 && y[31]) ? -y : y;
        hb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hb = i;
        return 2 + hb;
`else
        m  = y;
        hb = 0;
        return 33 + hb + int'(m[0] & 1'b0);
`endif
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int n, bc, lat;
        p   = ref_prod(o, x, y);
        lat = ref_lat(o, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~x; b = ~y;
        n = 0; bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".done_seen"}, {63'd0, done}, 64'd1);
        check({tag, ".latency"}, 64'(n), 64'(lat));
        check({tag, ".busy_cycles"}, 64'(bc), 64'(lat == 1 ? 0 : lat - 1));
        check({tag, ".err"}, {63'd0, err}, {63'd0, !(o == 3'b100 || o == 3'b101 || o == 3'b110)});
        check({tag, ".result"}, {result_hi, result_lo}, p);
        check({tag, ".nz"}, {62'd0, flags_nz}, {62'd0, ref_nz(o, p)});
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, ".hold"}, {result_hi, result_lo}, p);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int dcnt;
        reset = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", {63'd0, busy}, 64'd0);
        check("rst.done", {63'd0, done}, 64'd0);
        check("rst.err", {63'd0, err}, 64'd0);
        check("rst.result", {result_hi, result_lo}, 64'd0);
        check("rst.nz", {62'd0, flags_nz}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul7x6", 3'b100, 32'd7, 32'd6);
        run_op("umull_ff", 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("smull_m2x3", 3'b110, 32'hFFFFFFFE, 32'd3);
        run_op("smull_min", 3'b110, 32'h80000000, 32'h80000000);
        run_op("illegal", 3'b000, 32'd5, 32'd7);
        run_op("mul0x5", 3'b100, 32'd0, 32'd5);
        run_op("mul9x1", 3'b100, 32'd9, 32'd1);
        run_op("umull_b0", 3'b101, 32'h12345678, 32'd0);

        // Second start mid-run must be ignored.
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'hDEADBEEF; b = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcnt++;
                check("ignore.result", {result_hi, result_lo}, ref_prod(3'b101, 32'hDEADBEEF, 32'hCAFEF00D));
            end
        end
        check("ignore.done_count", 64'(dcnt), 64'd1);

        // Reset mid-run aborts with no done.
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'hFFFF0000; b = 32'h0000FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort.busy", {63'd0, busy}, 64'd0);
        check("abort.done", {63'd0, done}, 64'd0);
        check("abort.result", {result_hi, result_lo}, 64'd0);
        check("abort.nz", {62'd0, flags_nz}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort.no_done", 64'(dcnt), 64'd0);
        run_op("mul3x4", 3'b100, 32'd3, 32'd4);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0: ro = 3'b100;
                1: ro = 3'b101;
                2: ro = 3'b110;
                default: ro = 3'($urandom_range(0, 7));
            endcase
            ra = $urandom();
            rb = $urandom();
            if (t % 6 == 1) rb = rb >> $urandom_range(0, 31);
            if (t % 6 == 2) ra = 32'h80000000;
            run_op($sformatf("rnd%0d", t), ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
